// File: rtl/if_fetch_unit_if.sv
// Instruction-memory request/response handshake between the fetch stage and imem.
interface if_fetch_unit_if;
    localparam int unsigned XLEN = 32;

    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_ready;
    logic [XLEN-1:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ready, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ready, imem_rdata);
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs a variable-latency imem handshake and
// encodes stall, bubble and flush purely through the IF/ID register inputs.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   stall,
    input  logic                   redirect,
    input  logic [31:0]            redirect_addr,
    if_fetch_unit_if.master        imem,
    output logic [31:0]            instruction,
    output logic [31:0]            addressF,
    output logic [5:0]             opcode,
    output logic [31:0]            j_addr,
    output logic                   refresh,
    output logic                   refresh1
);
    localparam int unsigned XLEN = 32;
    localparam int unsigned OPW  = 6;

    typedef enum logic [1:0] {S_REQ, S_HOLD, S_DRAIN} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] buf_q, buf_d;
    logic [XLEN-1:0] buf_pc_q, buf_pc_d;
    logic [XLEN-1:0] drain_addr_q, drain_addr_d;
    logic [XLEN-1:0] instr_q, instr_d;
    logic [XLEN-1:0] addrf_q, addrf_d;
    logic [OPW-1:0]  opcode_q, opcode_d;
    logic [XLEN-1:0] jaddr_q, jaddr_d;
    logic            refresh_q, refresh_d;
    logic            refresh1_q, refresh1_d;
    logic [XLEN-1:0] fetch_addr;

    function automatic logic [XLEN-1:0] jump_target(input logic [XLEN-1:0] pc,
                                                    input logic [XLEN-1:0] word);
        logic [XLEN-1:0] pc_plus4;
        pc_plus4 = pc + XLEN'(4);
        return {pc_plus4[31:28], word[25:0], 2'b00};
    endfunction

    // While draining, the bus keeps showing the stale address until it completes.
    assign fetch_addr      = (state_q == S_DRAIN) ? drain_addr_q : pc_q;
    assign imem.imem_req   = (state_q != S_HOLD);
    assign imem.imem_addr  = fetch_addr;

    assign instruction = instr_q;
    assign addressF    = addrf_q;
    assign opcode      = opcode_q;
    assign j_addr      = jaddr_q;
    assign refresh     = refresh_q;
    assign refresh1    = refresh1_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_REQ;
            pc_q         <= RESET_PC;
            buf_q        <= '0;
            buf_pc_q     <= '0;
            drain_addr_q <= '0;
            instr_q      <= NOP_WORD;
            addrf_q      <= '0;
            opcode_q     <= '0;
            jaddr_q      <= '0;
            refresh_q    <= 1'b0;
            refresh1_q   <= 1'b1;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            buf_q        <= buf_d;
            buf_pc_q     <= buf_pc_d;
            drain_addr_q <= drain_addr_d;
            instr_q      <= instr_d;
            addrf_q      <= addrf_d;
            opcode_q     <= opcode_d;
            jaddr_q      <= jaddr_d;
            refresh_q    <= refresh_d;
            refresh1_q   <= refresh1_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        buf_d        = buf_q;
        buf_pc_d     = buf_pc_q;
        drain_addr_d = drain_addr_q;
        instr_d      = instr_q;
        addrf_d      = addrf_q;
        opcode_d     = opcode_q;
        jaddr_d      = jaddr_q;
        refresh_d    = 1'b0;
        refresh1_d   = refresh1_q;

        if (redirect) begin
            pc_d       = redirect_addr;
            buf_d      = '0;
            buf_pc_d   = '0;
            instr_d    = NOP_WORD;
            addrf_d    = '0;
            opcode_d   = '0;
            jaddr_d    = '0;
            refresh_d  = 1'b1;
            refresh1_d = 1'b0;
            if (state_q != S_HOLD && !imem.imem_ready) begin
                state_d      = S_DRAIN;
                drain_addr_d = fetch_addr;
            end else begin
                state_d = S_REQ;
            end
        end else if (state_q == S_DRAIN) begin
            instr_d    = NOP_WORD;
            opcode_d   = '0;
            jaddr_d    = '0;
            refresh1_d = 1'b1;
            if (imem.imem_ready) begin
                state_d = S_REQ;
            end
        end else if (stall) begin
            // Held flush degrades to a bubble so refresh pulses only once.
            refresh1_d = refresh1_q | refresh_q;
            if (state_q == S_REQ && imem.imem_ready) begin
                buf_d    = imem.imem_rdata;
                buf_pc_d = pc_q;
                pc_d     = pc_q + XLEN'(4);
                state_d  = S_HOLD;
            end
        end else if (state_q == S_HOLD) begin
            instr_d    = buf_q;
            addrf_d    = buf_pc_q;
            opcode_d   = buf_q[31:26];
            jaddr_d    = jump_target(buf_pc_q, buf_q);
            refresh1_d = 1'b0;
            state_d    = S_REQ;
        end else if (imem.imem_ready) begin
            instr_d    = imem.imem_rdata;
            addrf_d    = pc_q;
            opcode_d   = imem.imem_rdata[31:26];
            jaddr_d    = jump_target(pc_q, imem.imem_rdata);
            refresh1_d = 1'b0;
            pc_d       = pc_q + XLEN'(4);
        end else begin
            instr_d    = NOP_WORD;
            opcode_d   = '0;
            jaddr_d    = '0;
            refresh1_d = 1'b1;
        end
    end
endmodule

// File: doc/if_fetch_unit.md
Name: if_fetch_unit

Overview:
- Instruction-fetch stage; drives every input of the IF/ID pipeline register: instruction, addressF, opcode, j_addr, refresh, refresh1.
- Owns the PC and a variable-latency instruction-memory handshake.
- Accepts a stall from the hazard unit and a redirect from branch/jump resolution.
- The IF/ID register loads every clock, so this block encodes stall, bubble and flush purely through its outputs.

Parameters:
- RESET_PC, 32'h0000_0000, PC loaded on reset.
- NOP_WORD, 32'h0000_0000, word driven on instruction during bubbles and flushes.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-high.
- stall  input  1  hold IF outputs and PC this cycle.
- redirect  input  1  taken branch/jump resolved downstream.
- redirect_addr  input  32  new PC when redirect=1.
- imem_req  output  1  fetch request; held until imem_ready.
- imem_addr  output  32  fetch address; equals PC, stable while imem_req=1.
- imem_ready  input  1  rdata valid this cycle; completes the request.
- imem_rdata  input  32  fetched word.
- instruction  output  32  word presented to IF/ID.
- addressF  output  32  PC of instruction.
- opcode  output  6  instruction[31:26].
- j_addr  output  32  {addressF+4 [31:28], instruction[25:0], 2'b00}.
- refresh  output  1  flush IF/ID (redirect).
- refresh1  output  1  bubble into IF/ID (no valid word).

Behaviour:
- All outputs registered except imem_req and imem_addr, which are combinational from state and PC.
- Reset (async, any state): PC=RESET_PC, state=REQ, instruction=NOP_WORD, addressF=0, opcode=0, j_addr=0, refresh=0, refresh1=1, buffer empty.
- States:
  - REQ: imem_req=1.
  - HOLD: imem_req=0; fetched word buffered while stalled.
  - DRAIN: imem_req=1; stale request outstanding, response discarded.
- Priority each edge: redirect > stall > normal.
- REQ, imem_ready=1, stall=0:
  - instruction<=rdata, addressF<=PC, opcode and j_addr derived from rdata/PC.
  - refresh1<=0, PC<=PC+4, stay REQ.
  - Zero-wait throughput is one instruction per cycle.
- REQ, imem_ready=0, stall=0: instruction<=NOP_WORD, opcode<=0, j_addr<=0, refresh1<=1; PC unchanged.
- REQ, stall=1:
  - Output registers unchanged.
  - If imem_ready=1: buffer<=rdata, buffered PC<=PC, PC<=PC+4, go HOLD.
- HOLD, stall=1: stay; outputs and buffer unchanged.
- HOLD, stall=0: outputs<=buffer (refresh1<=0), go REQ.
- Redirect, any state:
  - PC<=redirect_addr, buffer cleared.
  - instruction<=NOP_WORD, opcode, j_addr and addressF<=0, refresh<=1, refresh1<=0.
  - If in REQ or DRAIN with imem_ready=0 (request outstanding): go DRAIN. Otherwise go REQ.
- refresh is high exactly one cycle per accepted redirect. Back-to-back redirects keep it high and the last address wins.
- DRAIN:
  - imem_addr shows the old address until imem_ready.
  - On imem_ready the data is discarded; go REQ for the new PC.
  - While draining, outputs are bubbles (refresh1=1, refresh=0 after the first cycle).
- refresh and refresh1 are never both 1.
- Stall with redirect: redirect wins; stall ignored that cycle.
- PC arithmetic is modulo 2^32; PC+4 wraps from 32'hFFFF_FFFC to 0.
- The j_addr upper nibble comes from addressF+4, so a PC of 32'h0FFF_FFFC yields 4'h1.

Test Plan:
- Reset, then imem_ready=1 every cycle with rdata=32'h0800_0010 at PC 0 → cycle 1: instruction=32'h0800_0010, addressF=0, opcode=6'h02, j_addr=32'h0000_0040, refresh1=0; addresses 0, 4, 8, … presented on consecutive cycles.
- imem_ready low 3 cycles at PC 8 → 3 bubble cycles (refresh1=1, instruction=NOP_WORD, imem_addr=8 stable), then word at addressF=8.
- stall=1 for 2 cycles while word at 12 arrives → outputs hold the addressF=8 word; imem_req=0 in HOLD; after release addressF=12 next cycle with no lost or duplicated word.
- redirect=1, redirect_addr=32'h0000_0100, during a zero-wait stream → next cycle refresh=1, instruction=NOP_WORD; the following fetch is at 32'h100.
- Redirect while imem_ready=0 at PC 16 → DRAIN; stale word returned later is not presented; then fetch at the new address; refresh pulsed exactly once.
- Async reset asserted mid-DRAIN between edges → outputs immediately take reset values; first fetch after release at RESET_PC; PC wrap check from 32'hFFFF_FFFC to 0.
